// File: rtl/arriskv_pkg.sv
// Shared types for the arriskv front end: fetch packets, fetch FSM states and
// the canonical NOP encoding.
package arriskv_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  typedef enum logic [1:0] {FS_BOOT, FS_FETCH, FS_DRAIN} fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/arriskv_fetch_fifo.sv
// Instruction buffer between imem responses and decode. The head is read
// straight from storage registers, so decode never sees imem_rdata combinationally.
module arriskv_fetch_fifo
  import arriskv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_pkt_t    push_pkt,
  input  logic          pop,
  output fetch_pkt_t    head_pkt,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_pkt_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_pkt;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign head_pkt = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/arriskv_fetch_stage.sv
// Instruction fetch stage: PC, pipelined imem requests, response buffer and
// redirect handling. Define ARRISKV_FETCH_PERF_EN to add stall/flush counters.
module arriskv_fetch_stage
  import arriskv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output fetch_pkt_t  fetch_pkt_o
`ifdef ARRISKV_FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;
  logic          fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic          rsp_live;
  logic [31:0]   redirect_target;
  logic [31:0]   rsp_pc;
  fetch_pkt_t    head_pkt, rsp_pkt;

  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
  assign credits_used    = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign rsp_live        = imem_rvalid_i && (inflight_q != '0);
  // Requests after a redirect are sequential, so the oldest in-flight
  // response belongs to pc_q minus one word per outstanding request.
  assign rsp_pc          = pc_q - (32'(inflight_q) << 2);
  assign rsp_pkt         = '{pc: rsp_pc, instr: imem_rdata_i};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    imem_req_o = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      FS_BOOT: begin
        state_d = FS_FETCH;
        if (redirect_i) pc_d = redirect_target;
      end
      FS_FETCH: begin
        if (redirect_i) begin
          pc_d       = redirect_target;
          fifo_flush = 1'b1;
          inflight_d = '0;
          discard_d  = inflight_q - CW'(rsp_live);
          state_d    = (discard_d != '0) ? FS_DRAIN : FS_FETCH;
        end else begin
          imem_req_o = credits_used < (CW+1)'(FIFO_DEPTH);
          if (imem_req_o && imem_gnt_i) pc_d = pc_q + 32'd4;
          inflight_d = inflight_q + CW'(imem_req_o && imem_gnt_i) - CW'(rsp_live);
          fifo_push  = rsp_live;
        end
      end
      FS_DRAIN: begin
        if (redirect_i) pc_d = redirect_target;
        if (imem_rvalid_i && discard_q != '0) discard_d = discard_q - CW'(1);
        if (discard_d == '0) state_d = FS_FETCH;
      end
      default: state_d = FS_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_BOOT;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  arriskv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_pkt (rsp_pkt),
    .pop      (fifo_pop),
    .head_pkt (head_pkt),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign imem_addr_o   = pc_q;
  assign fetch_valid_o = !fifo_empty;
  assign fifo_pop      = fetch_valid_o && fetch_ready_i;
  assign fetch_pkt_o   = fifo_empty ? '0 : head_pkt;

  rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (inflight_q != '0 || discard_q != '0));

`ifdef ARRISKV_FETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q != FS_BOOT) begin
      if (!fetch_valid_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_i && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_arriskv_fetch_stage.sv
// Randomised bench for arriskv_fetch_stage against an epoch-based packet model;
// a second instance with RESET_PC=0xFFFF_FFF8 covers address wrap.
module tb_arriskv_fetch_stage;
  import arriskv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, fetch_valid, fetch_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  fetch_pkt_t  fetch_pkt;
  logic        req2, rvalid2, valid2;
  logic [31:0] addr2, rdata2;
  fetch_pkt_t  pkt2;
`ifdef ARRISKV_FETCH_PERF_EN
  logic [31:0] perf_stall, perf_flush, perf_stall2, perf_flush2;
`endif

  always #5 clk = ~clk;

  arriskv_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .fetch_valid_o (fetch_valid),
    .fetch_ready_i (fetch_ready),
    .fetch_pkt_o   (fetch_pkt)
`ifdef ARRISKV_FETCH_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall),
    .perf_flush_cnt_o (perf_flush)
`endif
  );

  arriskv_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (req2),
    .imem_addr_o   (addr2),
    .imem_gnt_i    (1'b1),
    .imem_rvalid_i (rvalid2),
    .imem_rdata_i  (rdata2),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .fetch_valid_o (valid2),
    .fetch_ready_i (1'b1),
    .fetch_pkt_o   (pkt2)
`ifdef ARRISKV_FETCH_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall2),
    .perf_flush_cnt_o (perf_flush2)
`endif
  );

  typedef struct {
    logic [31:0] dut_addr;
    logic [31:0] exp_addr;
    int          cyc;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          vis;
  } epkt_t;

  mreq_t       mem_q[$];
  epkt_t       exp_q[$];
  logic [31:0] hs_addr[$];
  logic [31:0] xfer_pc[$];
  logic [31:0] addrs2[3];
  logic [31:0] exp_pc, first_pc;
  int          n_checks, n_errors;
  int          cyc, since_rst, epoch, n2, first_valid_at, stall_m, flush_m;
  int          gnt_pct, rsp_pct, rdy_pct;
  bit          last_req, hs2_prev;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive inputs at negedge, observe and update the model, advance.
  task automatic tick(input bit redir, input logic [31:0] tgt);
    bit    rsp, exp_valid, stale;
    mreq_t r;
    epkt_t e;
    imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    fetch_ready = ($urandom_range(0, 99) < rdy_pct);
    rsp = 1'b0;
    if (mem_q.size() > 0) rsp = (mem_q[0].cyc < cyc) && ($urandom_range(0, 99) < rsp_pct);
    imem_rvalid = rsp;
    imem_rdata  = $urandom();
    if (rsp) imem_rdata = mem_word(mem_q[0].dut_addr);
    redirect    = redir;
    redirect_pc = tgt;
    rvalid2     = hs2_prev;
    rdata2      = NOP_INSTR;
    #1;
    stale = 1'b0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale = 1'b1;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
    n_checks++;
    if (fetch_valid !== exp_valid) begin
      n_errors++;
      $display("[TB] FAIL fetch_valid cyc=%0d: got %b expected %b", cyc, fetch_valid, exp_valid);
    end
    if (fetch_valid === 1'b1 && first_valid_at < 0) begin
      first_valid_at = since_rst;
      first_pc       = fetch_pkt.pc;
    end
    if (exp_valid && fetch_ready) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fetch_pkt !== {e.pc, e.instr}) begin
        n_errors++;
        $display("[TB] FAIL fetch_pkt cyc=%0d: got %h expected %h", cyc, fetch_pkt, {e.pc, e.instr});
      end
      xfer_pc.push_back(fetch_pkt.pc);
    end
    if (redir || stale) begin
      n_checks++;
      if (imem_req !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL req_quiet cyc=%0d: got %b expected 0", cyc, imem_req);
      end
    end
    last_req = imem_req;
    if (imem_req === 1'b1 && imem_gnt) begin
      n_checks++;
      if (imem_addr !== exp_pc) begin
        n_errors++;
        $display("[TB] FAIL imem_addr cyc=%0d: got %h expected %h", cyc, imem_addr, exp_pc);
      end
      r.dut_addr = imem_addr;
      r.exp_addr = exp_pc;
      r.cyc      = cyc;
      r.epoch    = epoch;
      mem_q.push_back(r);
      hs_addr.push_back(imem_addr);
      exp_pc += 32'd4;
    end
    if (since_rst >= 1) begin
      if (!exp_valid) stall_m++;
      if (redir) flush_m++;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      exp_pc = tgt & 32'hFFFF_FFFC;
    end
    if (rsp) begin
      r = mem_q.pop_front();
      if (r.epoch == epoch) begin
        e.pc    = r.exp_addr;
        e.instr = mem_word(r.exp_addr);
        e.vis   = cyc + 1;
        exp_q.push_back(e);
      end
    end
    if (req2 === 1'b1 && n2 < 3) begin
      addrs2[n2] = addr2;
      n2++;
    end
    hs2_prev = (req2 === 1'b1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    since_rst++;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    fetch_ready = 1'b0;
    rvalid2     = 1'b0;
    #1;
    n_checks += 4;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL reset_req: got req=%b addr=%h expected req=0 addr=0", imem_req, imem_addr);
    end
    if (fetch_valid !== 1'b0 || fetch_pkt !== 64'h0) begin
      n_errors++;
      $display("[TB] FAIL reset_out: got valid=%b pkt=%h expected 0/0", fetch_valid, fetch_pkt);
    end
    if (addr2 !== 32'hFFFF_FFF8) begin
      n_errors++;
      $display("[TB] FAIL reset_pc_wrap: got %h expected fffffff8", addr2);
    end
`ifdef ARRISKV_FETCH_PERF_EN
    if (perf_stall !== 32'h0 || perf_flush !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL reset_perf: got stall=%0d flush=%0d expected 0/0", perf_stall, perf_flush);
    end
`else
    if (req2 !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_req_wrap: got %b expected 0", req2);
    end
`endif
    mem_q.delete();
    exp_q.delete();
    hs_addr.delete();
    xfer_pc.delete();
    exp_pc   = 32'h0;
    epoch++;
    n2       = 0;
    hs2_prev = 1'b0;
    stall_m  = 0;
    flush_m  = 0;
    first_valid_at = -1;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    cyc++;
    since_rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
    repeat (8) tick(1'b0, 32'h0);
    n_checks += 2;
    if (first_valid_at != 3 || first_pc !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL first_valid: got cycle %0d pc %h expected cycle 3 pc 0", first_valid_at, first_pc);
    end
    if (hs_addr.size() < 3 || hs_addr[0] !== 32'h0 || hs_addr[1] !== 32'h4 || hs_addr[2] !== 32'h8) begin
      n_errors++;
      $display("[TB] FAIL addr_seq: got %0d requests, first %h expected 0,4,8", hs_addr.size(), hs_addr[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 0;
    repeat (10) tick(1'b0, 32'h0);
    n_checks += 2;
    if (hs_addr.size() != DEPTH) begin
      n_errors++;
      $display("[TB] FAIL bp_grants: got %0d expected %0d", hs_addr.size(), DEPTH);
    end
    if (last_req !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL bp_req: got %b expected 0", last_req);
    end
    rdy_pct = 100;
    repeat (6) tick(1'b0, 32'h0);
    n_checks++;
    if (xfer_pc.size() < 2 || xfer_pc[0] !== 32'h0 || xfer_pc[1] !== 32'h4) begin
      n_errors++;
      $display("[TB] FAIL bp_order: got %0d packets first %h expected pc 0 then 4", xfer_pc.size(), xfer_pc[0]);
    end
  endtask

  task automatic test_redirect_drain();
    int n;
    do_reset();
    gnt_pct = 100; rsp_pct = 0; rdy_pct = 100;
    n = 0;
    while (mem_q.size() < 2 && n < 10) begin
      tick(1'b0, 32'h0);
      n++;
    end
    n_checks++;
    if (mem_q.size() != 2) begin
      n_errors++;
      $display("[TB] FAIL drain_inflight: got %0d outstanding expected 2", mem_q.size());
    end
    xfer_pc.delete();
    tick(1'b1, 32'h100);
    rsp_pct = 100;
    n = 0;
    while (xfer_pc.size() == 0 && n < 30) begin
      tick(1'b0, 32'h0);
      n++;
    end
    n_checks++;
    if (xfer_pc.size() == 0 || xfer_pc[0] !== 32'h100) begin
      n_errors++;
      $display("[TB] FAIL drain_next_pc: got %0d packets first %h expected 00000100", xfer_pc.size(), xfer_pc[0]);
    end
  endtask

  task automatic test_redirect_on_rvalid();
    int n;
    do_reset();
    gnt_pct = 100; rsp_pct = 0; rdy_pct = 100;
    n = 0;
    while (mem_q.size() < 1 && n < 10) begin
      tick(1'b0, 32'h0);
      n++;
    end
    gnt_pct = 0;
    tick(1'b0, 32'h0);
    rsp_pct = 100;
    xfer_pc.delete();
    tick(1'b1, 32'h0000_0243);
    n_checks++;
    if (mem_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL rv_redirect_rsp: got %0d outstanding expected 0", mem_q.size());
    end
    gnt_pct = 100;
    n = 0;
    while (xfer_pc.size() == 0 && n < 30) begin
      tick(1'b0, 32'h0);
      n++;
    end
    n_checks++;
    if (xfer_pc.size() == 0 || xfer_pc[0] !== 32'h240) begin
      n_errors++;
      $display("[TB] FAIL rv_redirect_pc: got %0d packets first %h expected 00000240", xfer_pc.size(), xfer_pc[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
    repeat (6) tick(1'b0, 32'h0);
    n_checks++;
    if (n2 != 3 || addrs2[0] !== 32'hFFFF_FFF8 || addrs2[1] !== 32'hFFFF_FFFC || addrs2[2] !== 32'h0) begin
      n_errors++;
      $display("[TB] FAIL wrap_addrs: got %0d reqs %h %h %h expected fffffff8 fffffffc 00000000",
               n2, addrs2[0], addrs2[1], addrs2[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = $urandom_range(30, 100);
        rsp_pct = $urandom_range(30, 100);
        rdy_pct = $urandom_range(20, 100);
      end
      if (i == 700) do_reset();
      tick(since_rst >= 1 && $urandom_range(0, 99) < 4, $urandom());
    end
    gnt_pct = 0; rsp_pct = 100; rdy_pct = 100;
    repeat (20) tick(1'b0, 32'h0);
    n_checks++;
    if (exp_q.size() != 0 || mem_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL random_drain: got %0d packets %0d requests left expected 0/0", exp_q.size(), mem_q.size());
    end
  endtask

`ifdef ARRISKV_FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    gnt_pct = 0; rsp_pct = 100; rdy_pct = 100;
    repeat (6) tick(1'b0, 32'h0);
    n_checks++;
    if (perf_stall !== 32'd5) begin
      n_errors++;
      $display("[TB] FAIL perf_stall5: got %0d expected 5", perf_stall);
    end
    gnt_pct = 100;
    repeat (4) tick(1'b0, 32'h0);
    tick(1'b1, 32'h100);
    repeat (4) tick(1'b0, 32'h0);
    tick(1'b1, 32'h200);
    repeat (4) tick(1'b0, 32'h0);
    tick(1'b1, 32'h300);
    repeat (6) tick(1'b0, 32'h0);
    n_checks += 2;
    if (perf_flush !== 32'd3) begin
      n_errors++;
      $display("[TB] FAIL perf_flush: got %0d expected 3", perf_flush);
    end
    if (perf_stall !== 32'(stall_m)) begin
      n_errors++;
      $display("[TB] FAIL perf_stall: got %0d expected %0d", perf_stall, stall_m);
    end
    do_reset();
  endtask
`endif

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; since_rst = 0; epoch = 0;
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_drain();
    test_redirect_on_rvalid();
    test_wrap();
    test_random();
`ifdef ARRISKV_FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
